ring_sequencer_ctrl: RTL
========================

// Module: ring_sequencer_ctrl
// PURPOSE
//  - Controller that sequences a one-hot N-phase ring, replacing free-running ring counters where phase timing must be gated.
//  - Runs a programmed number of full rotations on start; supports single-step and abort; reports busy/done.
//  - Sits between control logic and downstream phase-enabled datapath stages.
// PARAMETERS
//  NUMBER_OF_FLOPS  4  ring length (phases), >=2
//  CNT_W            8  width of rotation count / counter
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        async reset, active-low
//  start        in   1        begin sequence; sampled only in IDLE
//  abort        in   1        terminate immediately, no done pulse
//  step_mode    in   1        1 = advance only on step; latched at start
//  step         in   1        advance one phase (step mode only)
//  num_rot      in   CNT_W    full rotations to run; latched at start
//  phase_out    out  N        one-hot active phase; all-zero when not running
//  phase_valid  out  1        phase_out holds a live phase
//  busy         out  1        high in RUN/WAIT
//  done         out  1        one-cycle pulse after final phase
//  rot_cnt      out  CNT_W    completed rotations in current sequence
// BEHAVIOUR
//  - One clock domain: clk. Reset is asynchronous and active-low (rst_n).
//  - Reset (async assert, sync release): state=IDLE, phase_out=0, phase_valid=0, busy=0, done=0, rot_cnt=0.
//  - FSM states: IDLE, RUN, WAIT (step mode), DONE. All outputs registered.
//  - IDLE: start=1 latches num_rot and step_mode, clears rot_cnt.
//      num_rot==0 -> DONE (no phases driven).
//      else -> RUN (step_mode=0) or WAIT (step_mode=1); phase_out=1 (bit0), phase_valid=1 on the next cycle.
//  - RUN: phase_out rotates left by one each cycle (bit N-1 -> bit0).
//      Leaving bit N-1 increments rot_cnt.
//      If bit N-1 is active and rot_cnt==num_rot-1 -> DONE; phase_out=0, phase_valid=0.
//  - WAIT: identical to RUN, but the token advances only on cycles with step=1; otherwise it holds. Final-phase exit rule is the same.
//  - DONE: done=1 for exactly one cycle, busy=0, then IDLE. rot_cnt holds its final value until the next start.
//  - Total live cycles in RUN = N*num_rot; each phase is live exactly once per rotation.
//  - Latency: start sampled at edge k -> phase bit0 visible after edge k+1 -> done high after edge k+N*R+1.
//  - abort: highest priority in RUN/WAIT/DONE -> IDLE at next edge.
//      phase_out=0, busy=0, done=0; rot_cnt retains its partial count.
//  - Simultaneous start+abort in IDLE: abort wins, stay IDLE.
//  - start in non-IDLE states: ignored. step outside WAIT: ignored.
//  - step_mode or num_rot changes mid-sequence: no effect (latched values are used).
//  - rot_cnt cannot wrap: max num_rot = 2^CNT_W-1 completes exactly.
//  - Invariant: phase_out is one-hot or zero at every edge; never multi-hot.
// STRUCTURE
//  - Package ring_seq_pkg: typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} ring_seq_state_e; default param constants.
//  - Sub-module ring_token_shift: one-hot rotator with load/enable/clear, async active-low reset.
//  - Top holds FSM, latches and rotation counter.
// TESTING (N=4, CNT_W=8)
//  - Reset mid-RUN (rst_n low at cycle 3 of phase 0010) -> all outputs 0 immediately; IDLE after release.
//  - start, num_rot=2, step_mode=0 -> phase_out 0001,0010,0100,1000 x2 (8 cycles); rot_cnt 0->1->2; done 1 cycle; busy low.
//  - start, num_rot=0 -> no phase_valid; done pulses the cycle after start; rot_cnt=0.
//  - step_mode=1, num_rot=1, step on 4 cycles with gaps -> phase holds between steps; done only after 4th step.
//  - abort at phase 0100 of rotation 2 (num_rot=3) -> next cycle phase_out=0, busy=0, no done; rot_cnt=1.
//  - start re-asserted while busy and start+abort together in IDLE -> ignored/stay IDLE; one-hot assertion holds throughout.

Source files
------------

// File: rtl/ring_sequencer_ctrl_pkg.sv
// Shared types and default sizing for the ring sequencer controller.
package ring_seq_pkg;

  localparam int DEF_NUMBER_OF_FLOPS = 4;
  localparam int DEF_CNT_W           = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } ring_seq_state_e;

endpackage

// File: rtl/ring_sequencer_ctrl_if.sv
// Control/status bundle between the issuing controller and the ring sequencer.
//
// Handshake: no valid/ready pair. 'start' is a level sampled on a rising edge
// only while the sequencer is idle; 'step' is sampled on every edge but only
// acts in step mode; 'abort' acts on the next edge in any non-idle state.
// 'done' is a single-cycle pulse with no acknowledge.
interface ring_sequencer_ctrl_if #(
  parameter int NUMBER_OF_FLOPS = 4,
  parameter int CNT_W           = 8
);
  logic                       start;
  logic                       abort;
  logic                       step_mode;
  logic                       step;
  logic [CNT_W-1:0]           num_rot;
  logic [NUMBER_OF_FLOPS-1:0] phase_out;
  logic                       phase_valid;
  logic                       busy;
  logic                       done;
  logic [CNT_W-1:0]           rot_cnt;

  modport master (
    output start, abort, step_mode, step, num_rot,
    input  phase_out, phase_valid, busy, done, rot_cnt
  );

  modport slave (
    input  start, abort, step_mode, step, num_rot,
    output phase_out, phase_valid, busy, done, rot_cnt
  );
endinterface

// File: rtl/ring_token_shift.sv
// One-hot token rotator: clear beats load beats enable; rotates left with wrap.
module ring_token_shift #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic         i_en,
  output logic [N-1:0] o_phase,
  output logic         o_valid
);

  logic [N-1:0] r_phase;
  logic         r_valid;

  // Token register; load always places the token on bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_valid <= 1'b0;
    end else if (i_clr) begin
      r_phase <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_phase <= {{(N-1){1'b0}}, 1'b1};
      r_valid <= 1'b1;
    end else if (i_en) begin
      r_phase <= {r_phase[N-2:0], r_phase[N-1]};
    end
  end

  assign o_phase = r_phase;
  assign o_valid = r_valid;

endmodule

// File: rtl/ring_sequencer_ctrl.sv
// Gated N-phase ring sequencer: runs num_rot full rotations of a one-hot token,
// free-running or one phase per step, with abort and a one-cycle done pulse.
// The first edge in RUN/WAIT is an arm cycle that loads the token, so phase 0
// appears one edge after start is sampled.
module ring_sequencer_ctrl
  import ring_seq_pkg::*;
#(
  parameter int NUMBER_OF_FLOPS = DEF_NUMBER_OF_FLOPS,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ring_sequencer_ctrl_if.slave  bus,
  output ring_seq_state_e       o_dbg_state
);

  localparam int N = NUMBER_OF_FLOPS;

  ring_seq_state_e  r_state;
  ring_seq_state_e  w_state_nxt;
  logic [CNT_W-1:0] r_num_rot;
  logic [CNT_W-1:0] r_rot_cnt;
  logic             r_done;
  logic             r_busy;

  logic [N-1:0]     w_phase;
  logic             w_valid;
  logic             w_load;
  logic             w_en;
  logic             w_clr;
  logic             w_inc;
  logic             w_latch;
  logic             w_last;

  // Token is on the final phase of the final rotation.
  assign w_last = w_phase[N-1] && (r_rot_cnt == (r_num_rot - CNT_W'(1)));

  // Next-state and token control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_en        = 1'b0;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.abort && bus.start) begin
          w_latch     = 1'b1;
          w_state_nxt = bus.step_mode ? WAIT : RUN;
        end
      end
      RUN, WAIT: begin
        if (bus.abort) begin
          w_clr       = 1'b1;
          w_state_nxt = IDLE;
        end else if (!w_valid) begin
          // Arm cycle: zero rotations finish without ever driving a phase.
          if (r_num_rot == '0) w_state_nxt = DONE;
          else                 w_load      = 1'b1;
        end else if (r_state == RUN || bus.step) begin
          if (w_phase[N-1]) w_inc = 1'b1;
          if (w_last) begin
            w_clr       = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_en = 1'b1;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, latched rotation target, rotation counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_num_rot <= '0;
      r_rot_cnt <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt == DONE);
      r_busy  <= (w_state_nxt == RUN) || (w_state_nxt == WAIT);
      if (w_latch) begin
        r_num_rot <= bus.num_rot;
        r_rot_cnt <= '0;
      end else if (w_inc) begin
        r_rot_cnt <= r_rot_cnt + CNT_W'(1);
      end
    end
  end

  ring_token_shift #(.N(N)) u_token (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_load  (w_load),
    .i_en    (w_en),
    .o_phase (w_phase),
    .o_valid (w_valid)
  );

  assign bus.phase_out   = w_phase;
  assign bus.phase_valid = w_valid;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.rot_cnt     = r_rot_cnt;
  assign o_dbg_state     = r_state;

endmodule
